shift_divider: RTL and testbench
================================

Name: shift_divider

Overview:
- Iterative signed 32-bit divider: the inverse operation of the team's combinational shift-add multiplier.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit.
- Uses a start/done handshake so the 32-cycle latency is explicit to the controller.

Parameters:
- WIDTH, 32, operand width in bits for A, B, Q and R.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- A  input  WIDTH  signed dividend (two's complement).
- B  input  WIDTH  signed divisor (two's complement).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; Q, R and div_by_zero are valid from this cycle on.
- Q  output  WIDTH  signed quotient, truncated toward zero.
- R  output  WIDTH  signed remainder; takes the sign of the dividend.
- div_by_zero  output  1  set with done when B==0; cleared at the next accepted start.

Behaviour:
- Reset: synchronous, active-high, on one clock and one reset. At the rst edge:
  - FSM goes to IDLE.
  - busy=0, done=0, Q=0, R=0, div_by_zero=0.
  - Count and internal registers are cleared.
  - An operation in progress is abandoned; no done pulse is produced for it.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge t0 captures the sign flags of A and B, |A| and |B| (unsigned magnitudes; 0x80000000 maps to 0x80000000), and clears the partial remainder and count.
  - If B==0, go to FIX with the zero flag set; otherwise go to CALC.
  - busy=1 from t0.
- CALC: runs WIDTH edges. On each edge:
  - Shift {rem, dividend} left by 1.
  - Trial = rem - |B| at WIDTH+1 bits.
  - If the trial is non-negative, rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - count increments; after edge WIDTH go to FIX.
- FIX: one edge.
  - Q = negate(quotient) if the sign flags differ, else quotient.
  - R = negate(rem) if the dividend was negative, else rem.
  - Divide by zero: Q=all-ones, R=A unchanged, div_by_zero=1.
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start during DONE is ignored.
  - start in the following IDLE cycle is accepted.
- Latency:
  - Normal operation: start edge t0, done high after edge t0+WIDTH+2 (cycle 34 for WIDTH=32).
  - Divide by zero: done high after edge t0+2.
- Outputs: Q, R and div_by_zero hold their last values until the next FIX.
- Overflow: 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0 by natural wrap; no flag.
- start while busy=1 is ignored; operands are never re-sampled mid-operation.
- rst and start asserted together: rst wins.

Optional Feature:
- Macro: SHIFT_DIVIDER_FAST_ZERO_EN.
- Defined: in IDLE, if A==0 and B!=0, skip CALC and go straight to FIX with Q=0, R=0; done arrives at t0+2.
- Undefined: a zero dividend runs the full WIDTH-cycle CALC; results are identical (Q=0, R=0) and latency is WIDTH+2.

Decomposition:
- Shared package arith_pkg:
  - WIDTH default constant.
  - Enum div_state_t {IDLE, CALC, FIX, DONE}.
  - Latency constant DIV_LATENCY = WIDTH+2.
  - Function abs_mag and function neg2c (two's-complement negate), also used by the multiplier's sign handling.
- One sub-module, shift_subtractor: combinational single step.
  - Inputs: rem, next dividend bit, |B|.
  - Outputs: new rem, quotient bit.
  - Counterpart of the multiplier's adder stage; instantiated once and iterated over time.

Test Plan:
- A=100, B=7, start at t0 -> busy through cycle 33; done at cycle 34; Q=14, R=2, div_by_zero=0.
- A=-100 (0xFFFFFF9C), B=7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2); A=100, B=-7 -> Q=-14, R=2.
- A=5, B=0 -> done at cycle 2; Q=0xFFFFFFFF, R=5, div_by_zero=1. A following 9/3 -> div_by_zero=0, Q=3, R=0.
- A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0. A=0x80000000, B=1 -> Q=0x80000000, R=0.
- Start 100/7; pulse start again with 50/5 at cycle 5 -> second request ignored, result 14/2. Then assert rst at cycle 10 of a new op -> busy=0, Q=R=0, no done pulse.
- A=0, B=3 -> with SHIFT_DIVIDER_FAST_ZERO_EN defined, done at cycle 2; undefined, done at cycle 34; both give Q=0, R=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: default operand width, divider FSM states,
// latency constant and the sign-handling helpers also used by the multiplier.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DIV_LATENCY   = DEFAULT_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Two's-complement negate; the most negative value maps to itself.
  function automatic logic [DEFAULT_WIDTH-1:0] neg2c(input logic [DEFAULT_WIDTH-1:0] x);
    return ~x + DEFAULT_WIDTH'(1);
  endfunction

  // Unsigned magnitude of a signed operand; 0x80000000 stays 0x80000000,
  // which is correct once the result is read as unsigned.
  function automatic logic [DEFAULT_WIDTH-1:0] abs_mag(input logic [DEFAULT_WIDTH-1:0] x);
    return x[DEFAULT_WIDTH-1] ? neg2c(x) : x;
  endfunction

endpackage

// File: rtl/shift_subtractor.sv
// One restoring shift-subtract step: brings the next dividend bit into the
// partial remainder and subtracts the divisor magnitude if it fits.
module shift_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qBit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {1'b0, i_dvs};

  // A clear top bit on the WIDTH+1-bit trial means the divisor fit, so keep
  // the difference; otherwise restore the shifted remainder.
  always_comb begin
    o_qBit = ~w_trial[WIDTH];
    o_rem  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  end

endmodule

// File: rtl/shift_divider.sv
// Iterative signed divider, one quotient bit per clock, start/done handshake.
// Optional macro SHIFT_DIVIDER_FAST_ZERO_EN: a zero dividend with a non-zero
// divisor skips the iteration phase and finishes in the divide-by-zero time.
module shift_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t      r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_count;
  logic             r_negA;
  logic             r_negB;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_newRem;
  logic             w_qBit;
  logic             w_skipCalc;

`ifdef SHIFT_DIVIDER_FAST_ZERO_EN
  assign w_skipCalc = (A == '0) || (B == '0);
`else
  assign w_skipCalc = (B == '0);
`endif

  // The dividend register doubles as the quotient: its MSB feeds the step and
  // the new quotient bit enters at the LSB.
  shift_subtractor #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_newRem),
    .o_qBit(w_qBit)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

  // Control FSM with registered outputs; the done pulse lags the DONE state by
  // one edge, and a start seen during that pulse is not accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_count <= '0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !r_done) begin
            r_negA  <= A[WIDTH-1];
            r_negB  <= B[WIDTH-1];
            r_dvd   <= abs_mag(A);
            r_dvs   <= abs_mag(B);
            r_rem   <= '0;
            r_count <= '0;
            r_zero  <= (B == '0);
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= w_skipCalc ? FIX : CALC;
          end
        end
        CALC: begin
          r_rem   <= w_newRem;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_qBit};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_zero) begin
            r_q   <= '1;
            r_r   <= r_negA ? neg2c(r_dvd) : r_dvd;
            r_dbz <= 1'b1;
          end else begin
            r_q <= (r_negA ^ r_negB) ? neg2c(r_dvd) : r_dvd;
            r_r <= r_negA ? neg2c(r_rem) : r_rem;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider.sv
// Directed testbench for shift_divider: a vector table of signed divisions
// with hand-computed results and latencies, plus sequences for ignored starts
// and reset behaviour. Honours SHIFT_DIVIDER_FAST_ZERO_EN for zero dividends.
module tb_shift_divider;

  localparam int LAT_NORM = 34;
  localparam int LAT_ZERO = 2;
`ifdef SHIFT_DIVIDER_FAST_ZERO_EN
  localparam int LAT_ZDVD = 2;
`else
  localparam int LAT_ZDVD = 34;
`endif
  localparam int NVEC = 12;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_by_zero;

  int nChecks;
  int nErrors;
  vec_t vecs[NVEC];

  shift_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one division (caller is #1 after an edge), then waits for done and
  // checks latency, busy coverage, results and the single-cycle done pulse.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expDbz, input int expLat);
    int lat;
    logic busyGap;
    lat = 0;
    busyGap = 1'b0;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busyGap = 1'b1;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_busyHeld"}, 32'(busyGap), 32'd0);
    checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'd0);
    checkOutput({tag, "_q"}, Q, expQ);
    checkOutput({tag, "_r"}, R, expR);
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(expDbz));
    @(posedge clk);
    #1;
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int sawDone;
    nChecks = 0;
    nErrors = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, LAT_NORM};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, LAT_NORM};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, LAT_NORM};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, LAT_NORM};
    vecs[4]  = '{32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, LAT_ZERO};
    vecs[5]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0, LAT_NORM};
    vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, LAT_NORM};
    vecs[7]  = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0, LAT_NORM};
    vecs[8]  = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0, LAT_NORM};
    vecs[9]  = '{32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, LAT_ZERO};
    vecs[10] = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, LAT_NORM};
    vecs[11] = '{32'd0,         32'd3,         32'd0,         32'd0,         1'b0, LAT_ZDVD};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_q", Q, 32'd0);
    checkOutput("rst_r", R, 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    vecs[i].dbz, vecs[i].lat);
    end

    // A second start mid-operation must be ignored.
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    A = 32'd50;
    B = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sawDone = 0;
    for (int n = 7; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        sawDone = n;
        break;
      end
    end
    checkOutput("ign_lat", 32'(sawDone), 32'd34);
    checkOutput("ign_q", Q, 32'd14);
    checkOutput("ign_r", R, 32'd2);
    @(posedge clk);
    #1;

    // Reset mid-operation abandons the division with no done pulse.
    A = 32'd9;
    B = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_q", Q, 32'd0);
    checkOutput("mid_r", R, 32'd0);
    sawDone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1;
    end
    checkOutput("mid_noDone", 32'(sawDone), 32'd0);

    // Reset and start together: reset wins.
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    checkOutput("rstStart_busy", 32'(busy), 32'd0);

    // A clean operation still works after the aborted one.
    @(posedge clk);
    #1;
    applyStimulus("post", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_NORM);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
